muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read operands and produces a 64-bit result for the write-back path (register file WriteData).
- Multi-cycle with a start/busy/done handshake; the control unit stalls while busy is high.
- Radix-2: one product or quotient bit per cycle.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the iterative RV64M mul/div unit.
package muldiv_pkg;

  localparam int unsigned XlenDefault = 64;

  typedef logic [XlenDefault-1:0]   word_t;
  typedef logic [2*XlenDefault-1:0] dword_t;

  localparam word_t MinSigned = {1'b1, {(XlenDefault - 1) {1'b0}}};

  // funct3 encodings for the M extension
  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StCalc,
    StFix,
    StDone
  } state_e;

  function automatic word_t neg_word(word_t v);
    return ~v + 1'b1;
  endfunction

  function automatic dword_t neg_dword(dword_t v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue logic and the mul/div unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
);

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV64M multiply/divide unit: one product or quotient bit per cycle,
// with a start/busy/done handshake toward the control unit.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);

  state_e            state_q, state_d;
  logic [2:0]        fn_q, fn_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_rem, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;
  logic [XLEN-1:0]   fix_result;

  assign is_div = fn_q[2];

  // MULH/DIV/REM are fully signed; MULHSU only signs rs1.
  assign sign_a = a_q[XLEN-1] &
                  (fn_q == OpMulh || fn_q == OpMulhsu || fn_q == OpDiv || fn_q == OpRem);
  assign sign_b = b_q[XLEN-1] & (fn_q == OpMulh || fn_q == OpDiv || fn_q == OpRem);
  assign mag_a  = sign_a ? neg_word(a_q) : a_q;
  assign mag_b  = sign_b ? neg_word(b_q) : b_q;

  // Shift-add: acc = {partial high, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}.
  // Remainder stays below the divisor, so the diff's top bit is a clean borrow flag.
  assign div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_rem - {1'b0, mcand_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_step = {(div_ge ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

  assign prod = neg_q ? neg_dword(acc_q) : acc_q;
  assign quot = neg_q ? neg_word(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem  = neg_rem_q ? neg_word(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    unique case (fn_q)
      OpMul:                     fix_result = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fix_result = prod[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fix_result = quot;
      OpRem, OpRemu:             fix_result = rem;
      default:                   fix_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    a_d       = a_q;
    b_d       = b_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          fn_d    = bus.funct3;
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          state_d = StPrep;
        end
      end
      StPrep: begin
        if (is_div && b_q == '0) begin
          result_d = (fn_q == OpDiv || fn_q == OpDivu) ? '1 : a_q;
          state_d  = StDone;
        end else if ((fn_q == OpDiv || fn_q == OpRem) && a_q == MinSigned && b_q == '1) begin
          result_d = (fn_q == OpDiv) ? a_q : '0;
          state_d  = StDone;
        end else begin
          mcand_d   = mag_b;
          acc_d     = {{XLEN{1'b0}}, mag_a};
          neg_d     = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = '0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        acc_d = is_div ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_result;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      fn_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; cycle 0 is the cycle start is driven.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam logic [63:0] All1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Drives start in cycle 0, returns #1 into cycle 1 with operands scrambled.
  task automatic issue(input logic [2:0] fn, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = fn;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.op_a   = ~a;
    bus.op_b   = ~b;
    bus.funct3 = ~fn;
  endtask

  // Returns the cycle number in which done is seen (200 on timeout).
  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++;
    if (bus.result !== 64'd0) begin
      n_fail++; $display("FAIL reset_result got %h want 0", bus.result);
    end
  endtask

  task automatic test_mul_timing;
    issue(OpMul, 64'd7, 64'd6);
    for (int cyc = 1; cyc <= 68; cyc++) begin
      n_checks++;
      if (bus.busy !== (cyc <= 67)) begin
        n_fail++; $display("FAIL mul_busy cyc %0d got %b want %b", cyc, bus.busy, cyc <= 67);
      end
      n_checks++;
      if (bus.done !== (cyc == 67)) begin
        n_fail++; $display("FAIL mul_done cyc %0d got %b want %b", cyc, bus.done, cyc == 67);
      end
      if (cyc == 67) begin
        n_checks++;
        if (bus.result !== 64'd42) begin
          n_fail++; $display("FAIL mul_result got %h want 42", bus.result);
        end
      end
      if (cyc < 68) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_mul_high;
    logic [2:0]  fns[4];
    logic [63:0] exps[4];
    int          lat;
    fns[0] = OpMulh;   exps[0] = 64'd0;
    fns[1] = OpMulhu;  exps[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    fns[2] = OpMulhsu; exps[2] = All1;
    fns[3] = OpMul;    exps[3] = 64'd1;
    for (int i = 0; i < 4; i++) begin
      issue(fns[i], All1, All1);
      wait_done(lat);
      n_checks++;
      if (lat != 67) begin n_fail++; $display("FAIL mulh_lat fn %0d got %0d want 67", fns[i], lat); end
      n_checks++;
      if (bus.result !== exps[i]) begin
        n_fail++; $display("FAIL mulh_result fn %0d got %h want %h", fns[i], bus.result, exps[i]);
      end
    end
  endtask

  task automatic test_div_signed;
    logic [2:0]  fns[4];
    logic [63:0] exps[4];
    int          lat;
    fns[0] = OpDiv;  exps[0] = 64'hFFFF_FFFF_FFFF_FFFD;
    fns[1] = OpRem;  exps[1] = All1;
    fns[2] = OpDivu; exps[2] = 64'h7FFF_FFFF_FFFF_FFFC;
    fns[3] = OpRemu; exps[3] = 64'd1;
    for (int i = 0; i < 4; i++) begin
      issue(fns[i], 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      wait_done(lat);
      n_checks++;
      if (lat != 67) begin n_fail++; $display("FAIL div_lat fn %0d got %0d want 67", fns[i], lat); end
      n_checks++;
      if (bus.result !== exps[i]) begin
        n_fail++; $display("FAIL div_result fn %0d got %h want %h", fns[i], bus.result, exps[i]);
      end
    end
  endtask

  task automatic test_div_special;
    logic [2:0]  fns[6];
    logic [63:0] as[6], bs[6], exps[6];
    int          lat;
    fns[0] = OpDivu; as[0] = 64'h1234; bs[0] = 64'd0; exps[0] = All1;
    fns[1] = OpRem;  as[1] = 64'h1234; bs[1] = 64'd0; exps[1] = 64'h1234;
    fns[2] = OpDiv;  as[2] = 64'h1234; bs[2] = 64'd0; exps[2] = All1;
    fns[3] = OpRemu; as[3] = 64'h1234; bs[3] = 64'd0; exps[3] = 64'h1234;
    fns[4] = OpDiv;  as[4] = 64'h8000_0000_0000_0000; bs[4] = All1;
    exps[4] = 64'h8000_0000_0000_0000;
    fns[5] = OpRem;  as[5] = 64'h8000_0000_0000_0000; bs[5] = All1; exps[5] = 64'd0;
    for (int i = 0; i < 6; i++) begin
      issue(fns[i], as[i], bs[i]);
      wait_done(lat);
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL special_lat case %0d got %0d want 2", i, lat); end
      n_checks++;
      if (bus.result !== exps[i]) begin
        n_fail++; $display("FAIL special_result case %0d got %h want %h", i, bus.result, exps[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    issue(OpMul, 64'd3, 64'd5);
    for (int cyc = 1; cyc <= 69; cyc++) begin
      if (cyc == 10) begin
        bus.start = 1'b1; bus.funct3 = OpMul; bus.op_a = 64'd9; bus.op_b = 64'd9;
      end
      if (cyc == 11) bus.start = 1'b0;
      if (cyc == 67) begin
        bus.start = 1'b1; bus.funct3 = OpMul; bus.op_a = 64'd9; bus.op_b = 64'd9;
      end
      if (cyc == 68) bus.start = 1'b0;
      n_checks++;
      if (bus.done !== (cyc == 67)) begin
        n_fail++; $display("FAIL busy_start_done cyc %0d got %b want %b", cyc, bus.done, cyc == 67);
      end
      if (cyc == 67) begin
        n_checks++;
        if (bus.result !== 64'd15) begin
          n_fail++; $display("FAIL busy_start_result got %h want 15", bus.result);
        end
      end
      if (cyc >= 68) begin
        n_checks++;
        if (bus.busy !== 1'b0) begin
          n_fail++; $display("FAIL busy_start_done_cycle cyc %0d got busy %b want 0", cyc, bus.busy);
        end
      end
      if (cyc < 69) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_op;
    int lat;
    issue(OpDivu, 64'd100, 64'd7);
    for (int cyc = 1; cyc < 30; cyc++) begin @(posedge clk); #1; end
    reset = 1'b1;                          // cycle 30
    @(posedge clk); #1;                    // cycle 31
    reset = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", bus.done); end
    n_checks++;
    if (bus.result !== 64'd0) begin
      n_fail++; $display("FAIL midreset_result got %h want 0", bus.result);
    end
    bus.start = 1'b1; bus.funct3 = OpMul; bus.op_a = 64'd2; bus.op_b = 64'd3;
    @(posedge clk); #1;                    // cycle 32 relative to old op, 1 for the new one
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_accept got %b want 1", bus.busy); end
    wait_done(lat);
    n_checks++;
    if (lat != 67) begin n_fail++; $display("FAIL midreset_lat got %0d want 67", lat); end
    n_checks++;
    if (bus.result !== 64'd6) begin
      n_fail++; $display("FAIL midreset_new_result got %h want 6", bus.result);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(OpMul, 64'd2, 64'd3);
    wait_done(lat);
    n_checks++;
    if (bus.result !== 64'd6) begin n_fail++; $display("FAIL b2b_first got %h want 6", bus.result); end
    issue(OpDiv, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9);
    wait_done(lat);
    n_checks++;
    if (lat != 67) begin n_fail++; $display("FAIL b2b_lat got %0d want 67", lat); end
    n_checks++;
    if (bus.result !== 64'hFFFF_FFFF_FFFF_FFF2) begin
      n_fail++; $display("FAIL b2b_div got %h want fffffffffffffff2", bus.result);
    end
    issue(OpRem, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9);
    wait_done(lat);
    n_checks++;
    if (bus.result !== 64'd2) begin n_fail++; $display("FAIL b2b_rem got %h want 2", bus.result); end
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_div_signed();
    test_div_special();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
